// File: rtl/neander_memoria_if.sv
// Control-unit to memory bus for the Neander CPU: REM/RDM load controls, access strobes,
// preload port and the memory's status outputs.
interface neander_memoria_if;
  logic       cgREM;
  logic       sel;
  logic [7:0] PC;
  logic       cgRDM;
  logic [7:0] AC;
  logic       READ;
  logic       WRITE;
  logic       ldEn;
  logic [7:0] ldAddr;
  logic [7:0] ldData;
  logic [7:0] REM;
  logic [7:0] RDM;
  logic       ocupado;
  logic       pronto;
  logic       erro;

  modport master (
    output cgREM, sel, PC, cgRDM, AC, READ, WRITE, ldEn, ldAddr, ldData,
    input  REM, RDM, ocupado, pronto, erro
  );

  modport slave (
    input  cgREM, sel, PC, cgRDM, AC, READ, WRITE, ldEn, ldAddr, ldData,
    output REM, RDM, ocupado, pronto, erro
  );
endinterface

// File: rtl/neander_memoria.sv
// Neander 256x8 memory with REM/RDM registers and a fixed-latency READ/WRITE handshake.
// All outputs are registered; protocol violations raise a sticky erro flag.
module neander_memoria #(
  parameter int unsigned LAT = 2
) (
  input logic              clock,
  input logic              reset,
  neander_memoria_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} estadoT;

  localparam logic [1:0] CntInit = 2'(LAT - 1);

  estadoT     estado;
  logic [1:0] cnt;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rem;
  logic [7:0] rdm;
  logic       ocupado;
  logic       pronto;
  logic       erro;
  logic [7:0] mem [256];

  logic strobe;
  logic anyReq;

  assign strobe = bus.READ | bus.WRITE;
  assign anyReq = strobe | bus.cgREM | bus.cgRDM | bus.ldEn;

  assign bus.REM     = rem;
  assign bus.RDM     = rdm;
  assign bus.ocupado = ocupado;
  assign bus.pronto  = pronto;
  assign bus.erro    = erro;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= StIdle;
      cnt     <= 2'd0;
      addr    <= 8'h00;
      wdata   <= 8'h00;
      rem     <= 8'h00;
      rdm     <= 8'h00;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
      erro    <= 1'b0;
    end else begin
      pronto <= 1'b0;
      unique case (estado)
        StIdle: begin
          // Access latches the pre-edge REM/RDM, so same-cycle loads don't affect it.
          if (bus.cgREM) rem <= bus.sel ? rdm : bus.PC;
          if (bus.cgRDM) rdm <= bus.AC;
          if (strobe) begin
            addr    <= rem;
            wdata   <= rdm;
            cnt     <= CntInit;
            ocupado <= 1'b1;
            pronto  <= (LAT == 1);
            estado  <= bus.READ ? StRd : StWr;
          end
          if (bus.READ && bus.WRITE) erro <= 1'b1;
          if (bus.ldEn) begin
            if (strobe) erro <= 1'b1;
            else        mem[bus.ldAddr] <= bus.ldData;
          end
        end
        StRd, StWr: begin
          if (anyReq) erro <= 1'b1;
          if (cnt == 2'd0) begin
            if (estado == StRd) rdm <= mem[addr];
            else                mem[addr] <= wdata;
            ocupado <= 1'b0;
            estado  <= StIdle;
          end else begin
            cnt    <= cnt - 2'd1;
            // pronto is raised one edge early so it covers the completing cycle.
            pronto <= (cnt == 2'd1);
          end
        end
        default: estado <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_neander_memoria.sv
// Directed self-checking bench for neander_memoria at LAT=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_neander_memoria;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  neander_memoria_if bus ();

  neander_memoria #(.LAT(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clearIn();
    bus.cgREM  = 1'b0;
    bus.sel    = 1'b0;
    bus.PC     = 8'h00;
    bus.cgRDM  = 1'b0;
    bus.AC     = 8'h00;
    bus.READ   = 1'b0;
    bus.WRITE  = 1'b0;
    bus.ldEn   = 1'b0;
    bus.ldAddr = 8'h00;
    bus.ldData = 8'h00;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    clearIn();
    bus.ldEn   = 1'b1;
    bus.ldAddr = a;
    bus.ldData = d;
    tick();
    clearIn();
  endtask

  task automatic loadRegs(input logic [7:0] pc, input logic [7:0] ac);
    clearIn();
    bus.cgREM = 1'b1;
    bus.PC    = pc;
    bus.cgRDM = 1'b1;
    bus.AC    = ac;
    tick();
    clearIn();
  endtask

  // One-cycle strobe, then wait out the two busy cycles.
  task automatic access(input logic rd, input logic wr);
    bus.READ  = rd;
    bus.WRITE = wr;
    tick();
    clearIn();
    repeat (2) tick();
  endtask

  task automatic doReset();
    clearIn();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clearIn();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    checkVal("rst_rem", bus.REM, 8'h00);
    checkVal("rst_rdm", bus.RDM, 8'h00);
    checkVal("rst_ocupado", {7'd0, bus.ocupado}, 8'h00);
    checkVal("rst_pronto", {7'd0, bus.pronto}, 8'h00);
    checkVal("rst_erro", {7'd0, bus.erro}, 8'h00);

    // Known memory contents used by later tests.
    preload(8'h30, 8'h00);
    preload(8'h01, 8'hEE);
    preload(8'h02, 8'h44);
    preload(8'h20, 8'h11);

    // Preload then read with handshake timing.
    preload(8'h10, 8'h3C);
    bus.sel   = 1'b0;
    bus.PC    = 8'h10;
    bus.cgREM = 1'b1;
    tick();
    clearIn();
    checkVal("t1_rem", bus.REM, 8'h10);
    bus.READ = 1'b1;
    tick();
    clearIn();
    checkVal("t1_ocupado_c1", {7'd0, bus.ocupado}, 8'h01);
    checkVal("t1_pronto_c1", {7'd0, bus.pronto}, 8'h00);
    tick();
    checkVal("t1_ocupado_c2", {7'd0, bus.ocupado}, 8'h01);
    checkVal("t1_pronto_c2", {7'd0, bus.pronto}, 8'h01);
    tick();
    checkVal("t1_ocupado_done", {7'd0, bus.ocupado}, 8'h00);
    checkVal("t1_pronto_done", {7'd0, bus.pronto}, 8'h00);
    checkVal("t1_rdm", bus.RDM, 8'h3C);
    checkVal("t1_erro", {7'd0, bus.erro}, 8'h00);

    // Store path: write 0xA5 to 0x80, clobber RDM, read back.
    loadRegs(8'h80, 8'hA5);
    checkVal("t2_rdm_load", bus.RDM, 8'hA5);
    checkVal("t2_rem_load", bus.REM, 8'h80);
    access(1'b0, 1'b1);
    loadRegs(8'h80, 8'h00);
    access(1'b1, 1'b0);
    checkVal("t2_readback", bus.RDM, 8'hA5);
    checkVal("t2_erro", {7'd0, bus.erro}, 8'h00);

    // Collision: READ wins, WRITE of 0x99 dropped.
    loadRegs(8'h20, 8'h99);
    access(1'b1, 1'b1);
    checkVal("t3_rdm", bus.RDM, 8'h11);
    checkVal("t3_erro", {7'd0, bus.erro}, 8'h01);
    loadRegs(8'h20, 8'h00);
    access(1'b1, 1'b0);
    checkVal("t3_mem_kept", bus.RDM, 8'h11);

    // Busy violation: cgREM during RD.
    doReset();
    checkVal("t4_erro_cleared", {7'd0, bus.erro}, 8'h00);
    loadRegs(8'h10, 8'h00);
    bus.READ = 1'b1;
    tick();
    clearIn();
    bus.cgREM = 1'b1;
    bus.PC    = 8'h55;
    tick();
    clearIn();
    checkVal("t4_rem_held", bus.REM, 8'h10);
    tick();
    checkVal("t4_rdm", bus.RDM, 8'h3C);
    checkVal("t4_erro", {7'd0, bus.erro}, 8'h01);

    // Reset during the first write wait cycle.
    loadRegs(8'h30, 8'h77);
    bus.WRITE = 1'b1;
    tick();
    clearIn();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkVal("t5_rem", bus.REM, 8'h00);
    checkVal("t5_rdm", bus.RDM, 8'h00);
    checkVal("t5_ocupado", {7'd0, bus.ocupado}, 8'h00);
    checkVal("t5_pronto", {7'd0, bus.pronto}, 8'h00);
    checkVal("t5_erro", {7'd0, bus.erro}, 8'h00);
    loadRegs(8'h30, 8'hFF);
    access(1'b1, 1'b0);
    checkVal("t5_mem_kept", bus.RDM, 8'h00);

    // Same-cycle REM load and READ: access uses old REM.
    loadRegs(8'h01, 8'h00);
    bus.cgREM = 1'b1;
    bus.PC    = 8'h02;
    access(1'b1, 1'b0);
    checkVal("t6_rdm", bus.RDM, 8'hEE);
    checkVal("t6_rem", bus.REM, 8'h02);
    checkVal("t6_erro", {7'd0, bus.erro}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
